// File: rtl/credit_vc_out_port_if.sv
// Bundle of the per-output-port signals of credit_vc_out_port.
//
// Handshake: a flit (in_flit[i][v]) is offered while in_req[i][v] is high and
// is consumed in the same cycle in which in_gnt[i][v] is high; the upstream
// queue pops on in_gnt and must not depend on in_gnt to drive in_req.
// Downstream, out_v is a one-cycle valid pulse with no back-pressure; flow
// control is purely by credits returned on out_credit_gnt.
interface credit_vc_out_port_if #(
   parameter int NUM_IN = 3,
   parameter int VC_W   = 2,
   parameter int FW     = 25
);
   logic [NUM_IN-1:0][VC_W-1:0][FW-1:0] in_flit;
   logic [NUM_IN-1:0][VC_W-1:0]         in_req;
   logic [NUM_IN-1:0][VC_W-1:0]         in_gnt;
   logic [FW-1:0]                       out_flit;
   logic [VC_W-1:0]                     out_v;
   logic [VC_W-1:0]                     out_credit_gnt;
   logic [VC_W-1:0]                     credit_avail;

   // Upstream/downstream environment side
   modport master (
      output in_flit, in_req, out_credit_gnt,
      input  in_gnt, out_flit, out_v, credit_avail
   );

   // Output-port engine side
   modport slave (
      input  in_flit, in_req, out_credit_gnt,
      output in_gnt, out_flit, out_v, credit_avail
   );
endinterface

// File: rtl/credit_vc_out_port.sv
// credit_vc_out_port: one output direction of the credit-based pi-tree switch.
// Arbitrates NUM_IN inputs x VC_W virtual channels, gates each VC on its
// downstream credit count, and launches at most one flit per cycle through a
// registered output stage.
// Optional feature: define CREDIT_VC_OUT_PORT_STATS_EN to add per-VC
// flit_cnt / stall_cnt statistics ports.
module credit_vc_out_port #(
   parameter int NUM_IN        = 3,
   parameter int VC_W          = 2,
   parameter int A_W           = 8,
   parameter int D_W           = 16,
   parameter int VC_FIFO_DEPTH = 4,
   parameter int FAIR_VC_ARB   = 0,
   localparam int FW           = A_W + D_W + 1
) (
   input  logic clk,
   input  logic rst,
   credit_vc_out_port_if.slave bus
`ifdef CREDIT_VC_OUT_PORT_STATS_EN
   ,
   output logic [VC_W-1:0][31:0] flit_cnt,
   output logic [VC_W-1:0][31:0] stall_cnt
`endif
);

   localparam int CMAX = VC_FIFO_DEPTH - 1;
   localparam int CW   = $clog2(CMAX + 1);
   localparam int VPW  = (VC_W > 1) ? $clog2(VC_W) : 1;
   localparam int IPW  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam logic [CW-1:0] CMAX_C = CW'(CMAX);

   // Architectural state
   logic [VC_W-1:0][CW-1:0]   credit;
   logic [VPW-1:0]            vc_ptr;
   logic [VC_W-1:0][IPW-1:0]  in_ptr;

   // Arbitration results
   logic [VC_W-1:0]           vc_req;
   logic [VC_W-1:0]           vc_elig;
   logic                      vc_found;
   logic [VPW-1:0]            win_vc;
   logic [VC_W-1:0]           win_vc_oh;
   logic [NUM_IN-1:0]         sel_req;
   logic [IPW-1:0]            sel_ptr;
   logic                      in_found;
   logic [IPW-1:0]            win_in;
   logic [NUM_IN-1:0]         win_in_oh;
   logic                      grant;
   logic [NUM_IN-1:0][VC_W-1:0] gnt;
   logic [VC_W-1:0]           dec_vc;
   logic [FW-1:0]             sel_flit;

   // Per-VC request summary and eligibility (registered credit only, so a
   // credit returned this cycle cannot feed through to in_gnt).
   always_comb begin
      vc_req  = '0;
      vc_elig = '0;
      for (int v = 0; v < VC_W; v++) begin
         for (int i = 0; i < NUM_IN; i++) begin
            vc_req[v] = vc_req[v] | bus.in_req[i][v];
         end
         vc_elig[v] = vc_req[v] && (credit[v] != '0);
      end
   end

   // VC selection: search from vc_ptr (fair) or from VC 0 (static priority),
   // done as two ordered passes so no modulo index is needed.
   always_comb begin
      int start;
      start     = (FAIR_VC_ARB != 0) ? int'(vc_ptr) : 0;
      vc_found  = 1'b0;
      win_vc    = '0;
      win_vc_oh = '0;
      for (int c = 0; c < VC_W; c++) begin
         if (!vc_found && vc_elig[c] && (c >= start)) begin
            vc_found     = 1'b1;
            win_vc       = VPW'(c);
            win_vc_oh[c] = 1'b1;
         end
      end
      for (int c = 0; c < VC_W; c++) begin
         if (!vc_found && vc_elig[c] && (c < start)) begin
            vc_found     = 1'b1;
            win_vc       = VPW'(c);
            win_vc_oh[c] = 1'b1;
         end
      end
   end

   // Pick out the winning VC's request column and its input pointer.
   always_comb begin
      sel_req = '0;
      sel_ptr = '0;
      for (int v = 0; v < VC_W; v++) begin
         if (win_vc_oh[v]) begin
            sel_ptr = in_ptr[v];
            for (int i = 0; i < NUM_IN; i++) begin
               sel_req[i] = bus.in_req[i][v];
            end
         end
      end
   end

   // Input round-robin within the winning VC, starting at its pointer.
   always_comb begin
      in_found  = 1'b0;
      win_in    = '0;
      win_in_oh = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         if (!in_found && sel_req[i] && (i >= int'(sel_ptr))) begin
            in_found     = 1'b1;
            win_in       = IPW'(i);
            win_in_oh[i] = 1'b1;
         end
      end
      for (int i = 0; i < NUM_IN; i++) begin
         if (!in_found && sel_req[i] && (i < int'(sel_ptr))) begin
            in_found     = 1'b1;
            win_in       = IPW'(i);
            win_in_oh[i] = 1'b1;
         end
      end
   end

   // Grant decode and flit mux. Grants are held off during reset so that no
   // upstream queue pops a flit that the reset would then discard.
   always_comb begin
      grant    = vc_found && in_found && !rst;
      gnt      = '0;
      sel_flit = '0;
      dec_vc   = grant ? win_vc_oh : '0;
      for (int i = 0; i < NUM_IN; i++) begin
         for (int v = 0; v < VC_W; v++) begin
            gnt[i][v] = grant && win_in_oh[i] && win_vc_oh[v];
            if (gnt[i][v]) begin
               sel_flit = bus.in_flit[i][v];
            end
         end
      end
      bus.in_gnt = gnt;
   end

   // Credit-available flags come straight from the registered counters.
   always_comb begin
      bus.credit_avail = '0;
      for (int v = 0; v < VC_W; v++) begin
         bus.credit_avail[v] = (credit[v] != '0);
      end
   end

   // Per-VC credit counters: grant takes one, credit return gives one back,
   // both together cancel; an excess return saturates at CMAX.
   always_ff @(posedge clk) begin
      if (rst) begin
         credit <= {VC_W{CMAX_C}};
      end else begin
         for (int v = 0; v < VC_W; v++) begin
            if (dec_vc[v] && !bus.out_credit_gnt[v]) begin
               credit[v] <= credit[v] - CW'(1);
            end else if (!dec_vc[v] && bus.out_credit_gnt[v] && (credit[v] != CMAX_C)) begin
               credit[v] <= credit[v] + CW'(1);
            end
         end
      end
   end

   // Round-robin pointers advance past the winner only on a grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         vc_ptr <= '0;
         in_ptr <= '0;
      end else if (grant) begin
         vc_ptr <= (win_vc == VPW'(VC_W - 1)) ? '0 : win_vc + VPW'(1);
         for (int v = 0; v < VC_W; v++) begin
            if (win_vc_oh[v]) begin
               in_ptr[v] <= (win_in == IPW'(NUM_IN - 1)) ? '0 : win_in + IPW'(1);
            end
         end
      end
   end

   // Registered output stage; out_flit keeps its last value when idle.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.out_v    <= '0;
         bus.out_flit <= '0;
      end else begin
         bus.out_v <= dec_vc;
         if (grant) begin
            bus.out_flit <= sel_flit;
         end
      end
   end

`ifdef CREDIT_VC_OUT_PORT_STATS_EN
   // Per-VC launch and credit-stall counters, free-running and wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         flit_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         for (int v = 0; v < VC_W; v++) begin
            if (dec_vc[v]) begin
               flit_cnt[v] <= flit_cnt[v] + 32'd1;
            end
            if (vc_req[v] && (credit[v] == '0)) begin
               stall_cnt[v] <= stall_cnt[v] + 32'd1;
            end
         end
      end
   end
`endif

`ifdef SIMULATION
   // A credit returned while the counter is already full means downstream
   // returned more credits than it was sent flits.
   for (genvar v = 0; v < VC_W; v++) begin : g_credit_ovf
      a_credit_ovf : assert property (@(posedge clk) disable iff (rst)
         !(bus.out_credit_gnt[v] && !dec_vc[v] && (credit[v] == CMAX_C)));
   end
`endif

endmodule

// File: tb/tb_credit_vc_out_port.sv
// Bench for credit_vc_out_port: two instances (static and round-robin VC
// arbitration) share the same request/flit stimulus; each has its own
// downstream credit-return model and reference model.
module tb_credit_vc_out_port;
   localparam int NUM_IN = 3;
   localparam int VC_W   = 2;
   localparam int A_W    = 8;
   localparam int D_W    = 16;
   localparam int DEPTH  = 4;
   localparam int FW     = A_W + D_W + 1;
   localparam int CMAX   = DEPTH - 1;
   localparam int EW     = VC_W + FW;

   typedef logic [NUM_IN-1:0][VC_W-1:0]         req_t;
   typedef logic [NUM_IN-1:0][VC_W-1:0][FW-1:0] flit_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   credit_vc_out_port_if #(.NUM_IN(NUM_IN), .VC_W(VC_W), .FW(FW)) if0 ();
   credit_vc_out_port_if #(.NUM_IN(NUM_IN), .VC_W(VC_W), .FW(FW)) if1 ();

`ifdef CREDIT_VC_OUT_PORT_STATS_EN
   logic [VC_W-1:0][31:0] flit_cnt0, stall_cnt0, flit_cnt1, stall_cnt1;
`endif

   credit_vc_out_port #(.NUM_IN(NUM_IN), .VC_W(VC_W), .A_W(A_W), .D_W(D_W),
                        .VC_FIFO_DEPTH(DEPTH), .FAIR_VC_ARB(0)) dut0 (
      .clk(clk), .rst(rst), .bus(if0)
`ifdef CREDIT_VC_OUT_PORT_STATS_EN
      , .flit_cnt(flit_cnt0), .stall_cnt(stall_cnt0)
`endif
   );

   credit_vc_out_port #(.NUM_IN(NUM_IN), .VC_W(VC_W), .A_W(A_W), .D_W(D_W),
                        .VC_FIFO_DEPTH(DEPTH), .FAIR_VC_ARB(1)) dut1 (
      .clk(clk), .rst(rst), .bus(if1)
`ifdef CREDIT_VC_OUT_PORT_STATS_EN
      , .flit_cnt(flit_cnt1), .stall_cnt(stall_cnt1)
`endif
   );

   // ---------------- scoreboard state ----------------
   int errors = 0;
   int checks = 0;
   logic [EW-1:0] exp_q0[$];
   logic [EW-1:0] exp_q1[$];
   flit_t cur_flit;

   // Reference model: credits per VC, downstream occupancy, RR pointers.
   int m_credit [2][VC_W];
   int m_occ    [2][VC_W];
   int m_vcptr  [2];
   int m_inptr  [2][VC_W];
   int m_flit   [2][VC_W];
   int m_stall  [2][VC_W];
   logic [FW-1:0] m_last [2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset(input int k);
      for (int v = 0; v < VC_W; v++) begin
         m_credit[k][v] = CMAX;
         m_occ[k][v]    = 0;
         m_inptr[k][v]  = 0;
         m_flit[k][v]   = 0;
         m_stall[k][v]  = 0;
      end
      m_vcptr[k] = 0;
      m_last[k]  = '0;
   endtask

   // One cycle of the reference model for instance k (fair = k).
   task automatic model(input int k, input req_t req, input logic [VC_W-1:0] ret,
                        input req_t gnt_act, input logic [VC_W-1:0] cav_act);
      req_t gnt_exp;
      logic [VC_W-1:0] cav_exp;
      logic [EW-1:0] e;
      logic [VC_W-1:0] oh;
      logic vreq [VC_W];
      int wv, wi, start, c;
      for (int v = 0; v < VC_W; v++) cav_exp[v] = (m_credit[k][v] != 0);
      check($sformatf("credit_avail%0d", k), 64'(cav_act), 64'(cav_exp));
      gnt_exp = '0;
      if (rst) begin
         check($sformatf("in_gnt_rst%0d", k), 64'(gnt_act), 64'(gnt_exp));
         model_reset(k);
         e = '0;
      end else begin
         for (int v = 0; v < VC_W; v++) begin
            vreq[v] = 1'b0;
            for (int i = 0; i < NUM_IN; i++) if (req[i][v]) vreq[v] = 1'b1;
         end
         start = (k == 1) ? m_vcptr[k] : 0;
         wv = -1;
         for (int off = 0; off < VC_W; off++) begin
            c = (start + off) % VC_W;
            if (wv < 0 && vreq[c] && m_credit[k][c] > 0) wv = c;
         end
         wi = -1;
         if (wv >= 0) begin
            for (int off = 0; off < NUM_IN; off++) begin
               c = (m_inptr[k][wv] + off) % NUM_IN;
               if (wi < 0 && req[c][wv]) wi = c;
            end
            gnt_exp[wi][wv] = 1'b1;
         end
         check($sformatf("in_gnt%0d", k), 64'(gnt_act), 64'(gnt_exp));
         for (int v = 0; v < VC_W; v++) begin
            if (vreq[v] && m_credit[k][v] == 0) m_stall[k][v]++;
            if (ret[v]) m_credit[k][v]++;
         end
         if (wv >= 0) begin
            m_credit[k][wv]--;
            m_occ[k][wv]++;
            m_flit[k][wv]++;
            m_vcptr[k]     = (wv + 1) % VC_W;
            m_inptr[k][wv] = (wi + 1) % NUM_IN;
            m_last[k]      = cur_flit[wi][wv];
            oh = '0;
            oh[wv] = 1'b1;
            e = {oh, m_last[k]};
         end else begin
            e = {{VC_W{1'b0}}, m_last[k]};
         end
      end
      if (k == 0) exp_q0.push_back(e);
      else exp_q1.push_back(e);
   endtask

   // ---------------- driver ----------------
   // cmode: 0 no credit return, 1 return one per VC whenever a flit is
   // outstanding, 2 random return, 3 single return on VC0 only.
   task automatic step(input req_t req, input int cmode, input logic r);
      logic [VC_W-1:0] ret [2];
      @(negedge clk);
      rst = r;
      for (int i = 0; i < NUM_IN; i++)
         for (int v = 0; v < VC_W; v++) cur_flit[i][v] = FW'($urandom);
      if0.in_flit = cur_flit;
      if1.in_flit = cur_flit;
      if0.in_req  = req;
      if1.in_req  = req;
      for (int k = 0; k < 2; k++) begin
         ret[k] = '0;
         for (int v = 0; v < VC_W; v++) begin
            if (m_occ[k][v] > 0) begin
               case (cmode)
                  1: ret[k][v] = 1'b1;
                  2: ret[k][v] = ($urandom_range(0, 1) == 1);
                  3: ret[k][v] = (v == 0);
                  default: ret[k][v] = 1'b0;
               endcase
            end
            if (ret[k][v]) m_occ[k][v]--;
         end
      end
      if0.out_credit_gnt = ret[0];
      if1.out_credit_gnt = ret[1];
      #1;
      model(0, req, ret[0], if0.in_gnt, if0.credit_avail);
      model(1, req, ret[1], if1.in_gnt, if1.credit_avail);
   endtask

   // ---------------- monitors ----------------
   logic [EW-1:0] e0, e1;
   always @(posedge clk) begin
      #2;
      if (exp_q0.size() > 0) begin
         e0 = exp_q0.pop_front();
         check("out0", 64'({if0.out_v, if0.out_flit}), 64'(e0));
      end
   end
   always @(posedge clk) begin
      #2;
      if (exp_q1.size() > 0) begin
         e1 = exp_q1.pop_front();
         check("out1", 64'({if1.out_v, if1.out_flit}), 64'(e1));
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      req_t rq;
      if0.in_req = '0; if1.in_req = '0;
      if0.in_flit = '0; if1.in_flit = '0;
      if0.out_credit_gnt = '0; if1.out_credit_gnt = '0;
      cur_flit = '0;
      model_reset(0);
      model_reset(1);

      // reset for 2 cycles
      repeat (2) step('0, 0, 1'b1);

      // credit exhaustion on VC0 then a single credit pulse
      rq = '0; rq[0][0] = 1'b1;
      repeat (6) step(rq, 0, 1'b0);
      step(rq, 3, 1'b0);
      repeat (3) step(rq, 0, 1'b0);

      // grant + return in the same cycle at credit 1
      repeat (8) step(rq, 1, 1'b0);

      // input fairness on VC1
      rq = '0;
      for (int i = 0; i < NUM_IN; i++) rq[i][1] = 1'b1;
      repeat (9) step(rq, 1, 1'b0);

      // both VCs from input 0
      rq = '0; rq[0] = '1;
      repeat (8) step(rq, 1, 1'b0);

      // reset mid-stream after two VC0 grants
      rq = '0; rq[0][0] = 1'b1;
      repeat (2) step(rq, 0, 1'b0);
      step(rq, 0, 1'b1);
      repeat (3) step(rq, 1, 1'b0);

      // random traffic, random credit return, occasional reset
      for (int n = 0; n < 600; n++) begin
         rq = req_t'($urandom);
         step(rq, 2, ($urandom_range(0, 99) == 0));
      end

      repeat (4) step('0, 1, 1'b0);
      @(posedge clk);
      #3;
      check("q0_drained", 64'(exp_q0.size()), 64'd0);
      check("q1_drained", 64'(exp_q1.size()), 64'd0);

`ifdef CREDIT_VC_OUT_PORT_STATS_EN
      for (int v = 0; v < VC_W; v++) begin
         check("flit_cnt0", 64'(flit_cnt0[v]), 64'(m_flit[0][v]));
         check("stall_cnt0", 64'(stall_cnt0[v]), 64'(m_stall[0][v]));
         check("flit_cnt1", 64'(flit_cnt1[v]), 64'(m_flit[1][v]));
         check("stall_cnt1", 64'(stall_cnt1[v]), 64'(m_stall[1][v]));
      end
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
